ring_decoder: RTL and testbench
===============================

# ring_decoder

Receiver-side companion to the team's one-hot ring counter: samples a WIDTH-bit one-hot ring code each valid cycle and converts it to a binary phase index. It checks the code is legal and that each step follows the ring sequence. It acquires and holds lock on a healthy ring, and counts full rotations and sequence errors. It sits downstream of any ring counter to give control logic a binary phase plus health status.

## Interface
- WIDTH, 4: ring length (bits in one-hot code), ≥2
- LOCK_CNT, 2: consecutive correct steps required to declare lock, ≥1
- ROT_W, 8: width of rotation counter
- ERR_W, 8: width of error counter
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- ring_in  in  WIDTH  one-hot ring code from counter
- ring_vld  in  1  ring_in carries a new step this cycle
- clr  in  1  synchronous clear of rot_count and err_count
- phase  out  $clog2(WIDTH)  binary index of set bit of last legal code
- phase_vld  out  1  one-cycle pulse: phase updated
- locked  out  1  high while FSM in LOCKED
- illegal  out  1  one-cycle pulse: sampled code not one-hot (incl. all-zero)
- seq_err  out  1  one-cycle pulse: bad step while LOCKED
- rot_count  out  ROT_W  completed rotations while LOCKED, wraps
- err_count  out  ERR_W  seq_err events, saturates at all-ones

## Operation
- Ring sequence: bit i → bit i+1, bit WIDTH-1 → bit 0 (WIDTH=4: 0001→0010→0100→1000→0001). expected = rotate-left of prev.
- ring_vld=0: no state change, all pulses low, phase held.
- Legal = exactly one bit set. Legal sample: prev ← ring_in, phase ← index, phase_vld pulse, in every state.
- Illegal sample: illegal pulse, prev and phase unchanged.
- FSM states SEARCH, TRACK, LOCKED; internal good counter.
  - SEARCH: legal → TRACK, good=0. Illegal → stay.
  - TRACK: legal == expected → good+1; if good+1 == LOCK_CNT → LOCKED. Legal ≠ expected → stay, good=0. Illegal → SEARCH.
  - LOCKED: legal == expected → stay; if ring_in == bit 0 set, rot_count+1. Legal ≠ expected (incl. repeated code) → seq_err, TRACK, good=0. Illegal → seq_err and illegal both pulse, SEARCH.
- seq_err increments err_count (saturating).
- Entering LOCKED on a 1000→0001 step does not count a rotation. Rotations count only on steps taken while already LOCKED.
- clr: both counters ← 0. clr wins over a same-cycle increment. FSM, phase and locked are unaffected.

## Timing
- All outputs registered. Sample at edge N → outputs valid after edge N (1-cycle latency).
- locked rises the cycle after the LOCK_CNT-th good step. It falls the cycle after the offending sample.
- Reset (any time, asynchronous assert): state SEARCH, good=0, prev=0, phase=0, all pulses 0, locked=0, rot_count=0, err_count=0. Reset deassertion resynchronised externally. First valid sample after reset is treated as in SEARCH.
- Back-to-back ring_vld every cycle is supported; no backpressure.

## Structure
- Package ring_pkg: state enum (SEARCH, TRACK, LOCKED), onehot-legal check function, rotate-left function.
- Sub-module ring_onehot_enc: combinational one-hot → binary index plus legal flag, parameterised by WIDTH; instantiated once.
- Top holds the FSM, prev/good registers and counters.

## Test plan
- Reset, then feed 0001,0010,0100 on consecutive cycles (WIDTH=4, LOCK_CNT=2) → phase 0,1,2; locked=1 after 0100 sample; illegal=seq_err=0.
- Locked ring, feed 1000,0001,0010,0100,1000,0001 → rot_count increments to 2 (on each 0001), phase tracks 3,0,1,2,3,0.
- Locked, feed 0001 twice → second sample: seq_err pulse, err_count=1, locked=0, state TRACK. Then 0010,0100 → relock.
- Feed 0000 then 0110 in SEARCH → illegal pulses twice, phase holds 0, no seq_err. Feed 0110 while LOCKED → illegal+seq_err same cycle, SEARCH.
- ring_vld low gaps between legal steps → no effect; lock still acquired. clr asserted with rotation step → rot_count=0.
- Assert reset mid-rotation while LOCKED with rot_count=5 → all outputs zero immediately. err_count forced to 255 then one more seq_err → stays 255.

Source files
------------

// File: rtl/ring_pkg.sv
// Shared types and helpers for the one-hot ring decoder.
package ring_pkg;

   // Widest ring the helper functions handle.
   localparam int unsigned MaxWidth = 64;

   typedef enum logic [1:0] {
      StSearch,
      StTrack,
      StLocked
   } ring_state_e;

   // True when exactly one of the low 'width' bits is set.
   function automatic logic onehot_legal(input logic [MaxWidth-1:0] code,
                                         input int unsigned         width);
      logic [MaxWidth-1:0] mask;
      logic [MaxWidth-1:0] v;
      mask = (width >= MaxWidth) ? '1 : ((MaxWidth'(1) << width) - MaxWidth'(1));
      v    = code & mask;
      return (v != '0) && ((v & (v - MaxWidth'(1))) == '0);
   endfunction

   // Rotate the low 'width' bits left by one (top bit wraps to bit 0).
   function automatic logic [MaxWidth-1:0] rotl(input logic [MaxWidth-1:0] code,
                                                input int unsigned         width);
      logic [MaxWidth-1:0] mask;
      logic [MaxWidth-1:0] v;
      mask = (width >= MaxWidth) ? '1 : ((MaxWidth'(1) << width) - MaxWidth'(1));
      v    = code & mask;
      return ((v << 1) | (v >> (width - 1))) & mask;
   endfunction

endpackage

// File: rtl/ring_onehot_enc.sv
// Combinational one-hot to binary encoder with a legality flag.
module ring_onehot_enc
   import ring_pkg::*;
#(
   parameter int unsigned WIDTH = 4
) (
   input  logic [WIDTH-1:0]         code,
   output logic [$clog2(WIDTH)-1:0] index,
   output logic                     legal
);

   localparam int unsigned IdxW = $clog2(WIDTH);

   // Index of the highest set bit; only meaningful when legal is high.
   always_comb begin
      index = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         if (code[i]) begin
            index = IdxW'(i);
         end
      end
      legal = onehot_legal(MaxWidth'(code), WIDTH);
   end

endmodule

// File: rtl/ring_decoder.sv
// Ring code receiver: binary phase, lock tracking, rotation and error counts.
module ring_decoder
   import ring_pkg::*;
#(
   parameter int unsigned WIDTH    = 4,
   parameter int unsigned LOCK_CNT = 2,
   parameter int unsigned ROT_W    = 8,
   parameter int unsigned ERR_W    = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [WIDTH-1:0]         ring_in,
   input  logic                     ring_vld,
   input  logic                     clr,
   output logic [$clog2(WIDTH)-1:0] phase,
   output logic                     phase_vld,
   output logic                     locked,
   output logic                     illegal,
   output logic                     seq_err,
   output logic [ROT_W-1:0]         rot_count,
   output logic [ERR_W-1:0]         err_count
);

   localparam int unsigned IdxW  = $clog2(WIDTH);
   localparam int unsigned GoodW = $clog2(LOCK_CNT + 1);

   ring_state_e        state_q;
   logic [GoodW-1:0]   good_q;
   logic [WIDTH-1:0]   prev_q;
   logic [WIDTH-1:0]   expected;
   logic [IdxW-1:0]    in_index;
   logic               in_legal;
   logic               step_ok;
   logic               good_done;

   ring_onehot_enc #(
      .WIDTH (WIDTH)
   ) u_enc (
      .code  (ring_in),
      .index (in_index),
      .legal (in_legal)
   );

   // Next code in the ring sequence; prev of zero after reset never matches.
   always_comb begin
      expected  = WIDTH'(rotl(MaxWidth'(prev_q), WIDTH));
      step_ok   = in_legal && (ring_in == expected);
      good_done = (int'(good_q) + 1) == int'(LOCK_CNT);
   end

   // FSM, sample history, registered status pulses and counters.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= StSearch;
         good_q    <= '0;
         prev_q    <= '0;
         phase     <= '0;
         phase_vld <= 1'b0;
         locked    <= 1'b0;
         illegal   <= 1'b0;
         seq_err   <= 1'b0;
         rot_count <= '0;
         err_count <= '0;
      end else begin
         phase_vld <= 1'b0;
         illegal   <= 1'b0;
         seq_err   <= 1'b0;
         if (ring_vld) begin
            if (in_legal) begin
               prev_q    <= ring_in;
               phase     <= in_index;
               phase_vld <= 1'b1;
            end else begin
               illegal <= 1'b1;
            end
            unique case (state_q)
               StSearch: begin
                  if (in_legal) begin
                     state_q <= StTrack;
                     good_q  <= '0;
                  end
               end
               StTrack: begin
                  if (!in_legal) begin
                     state_q <= StSearch;
                     good_q  <= '0;
                  end else if (step_ok) begin
                     if (good_done) begin
                        state_q <= StLocked;
                        locked  <= 1'b1;
                        good_q  <= '0;
                     end else begin
                        good_q <= good_q + GoodW'(1);
                     end
                  end else begin
                     good_q <= '0;
                  end
               end
               StLocked: begin
                  if (step_ok) begin
                     // A step landing on bit 0 closes one full rotation.
                     if (ring_in[0]) begin
                        rot_count <= rot_count + ROT_W'(1);
                     end
                  end else begin
                     seq_err <= 1'b1;
                     locked  <= 1'b0;
                     good_q  <= '0;
                     state_q <= in_legal ? StTrack : StSearch;
                     if (err_count != '1) begin
                        err_count <= err_count + ERR_W'(1);
                     end
                  end
               end
               default: begin
                  state_q <= StSearch;
                  locked  <= 1'b0;
                  good_q  <= '0;
               end
            endcase
         end
         // Clear overrides any increment scheduled above.
         if (clr) begin
            rot_count <= '0;
            err_count <= '0;
         end
      end
   end

endmodule

// File: tb/tb_ring_decoder.sv
// Self-checking bench for ring_decoder against an index-based reference model.
module tb_ring_decoder;

   localparam int W = 4;

   logic       clk;
   logic       reset;
   logic [3:0] ring_in;
   logic       ring_vld;
   logic       clr;
   logic [1:0] phase;
   logic       phase_vld;
   logic       locked;
   logic       illegal;
   logic       seq_err;
   logic [7:0] rot_count;
   logic [7:0] err_count;
   logic [21:0] dut_vec;

   int compared;
   int mismatched;

   // Reference model: phase as an integer index, state as a small integer.
   int m_state;     // 0 searching, 1 tracking, 2 locked
   int m_good;
   int m_prev_idx;  // -1 means no legal code seen since reset
   int m_phase;
   int m_pvld, m_ill, m_seq, m_rot, m_err;

   ring_decoder #(
      .WIDTH    (4),
      .LOCK_CNT (2),
      .ROT_W    (8),
      .ERR_W    (8)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .ring_in   (ring_in),
      .ring_vld  (ring_vld),
      .clr       (clr),
      .phase     (phase),
      .phase_vld (phase_vld),
      .locked    (locked),
      .illegal   (illegal),
      .seq_err   (seq_err),
      .rot_count (rot_count),
      .err_count (err_count)
   );

   assign dut_vec = {phase, phase_vld, locked, illegal, seq_err, rot_count, err_count};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_reset();
      m_state = 0; m_good = 0; m_prev_idx = -1; m_phase = 0;
      m_pvld = 0; m_ill = 0; m_seq = 0; m_rot = 0; m_err = 0;
   endtask

   task automatic model_step(input logic [3:0] code, input logic vld, input logic c);
      int  idx;
      bit  legal;
      bit  ok;
      m_pvld = 0; m_ill = 0; m_seq = 0;
      if (vld) begin
         legal = ($countones(code) == 1);
         idx = 0;
         for (int i = 0; i < W; i++) if (code[i]) idx = i;
         ok = legal && (m_prev_idx >= 0) && (idx == (m_prev_idx + 1) % W);
         if (m_state == 0) begin
            if (legal) begin m_state = 1; m_good = 0; end
         end else if (m_state == 1) begin
            if (!legal) begin m_state = 0; m_good = 0; end
            else if (ok) begin
               m_good++;
               if (m_good == 2) begin m_state = 2; m_good = 0; end
            end else m_good = 0;
         end else begin
            if (ok) begin
               if (idx == 0) m_rot = (m_rot + 1) % 256;
            end else begin
               m_seq = 1;
               m_err = (m_err < 255) ? m_err + 1 : 255;
               m_state = legal ? 1 : 0;
               m_good = 0;
            end
         end
         if (legal) begin m_prev_idx = idx; m_phase = idx; m_pvld = 1; end
         else m_ill = 1;
      end
      if (c) begin m_rot = 0; m_err = 0; end
   endtask

   function automatic logic [21:0] model_vec();
      return {2'(m_phase), 1'(m_pvld), (m_state == 2), 1'(m_ill), 1'(m_seq),
              8'(m_rot), 8'(m_err)};
   endfunction

   // One clock: inputs set after the previous edge, model advanced at the edge.
   task automatic cycle(input logic [3:0] code, input logic vld, input logic c);
      ring_in = code; ring_vld = vld; clr = c;
      @(posedge clk);
      model_step(code, vld, c);
      #1;
      ring_vld = 1'b0; clr = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      ring_vld = 1'b0; clr = 1'b0; ring_in = '0;
      model_reset();
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      do_reset();
      compared++;
      if (dut_vec !== 22'd0) begin
         mismatched++;
         $display("FAIL reset_state: got %h want %h", dut_vec, 22'd0);
      end
      cycle(4'b0100, 1'b0, 1'b0);
      compared++;
      if (dut_vec !== model_vec()) begin
         mismatched++;
         $display("FAIL reset_idle_vld0: got %h want %h", dut_vec, model_vec());
      end
   endtask

   task automatic test_lock();
      logic [3:0] seq [3] = '{4'b0001, 4'b0010, 4'b0100};
      for (int i = 0; i < 3; i++) begin
         cycle(seq[i], 1'b1, 1'b0);
         compared++;
         if (dut_vec !== model_vec()) begin
            mismatched++;
            $display("FAIL lock step %0d: got %h want %h", i, dut_vec, model_vec());
         end
      end
      compared++;
      if (locked !== 1'b1 || phase !== 2'd2) begin
         mismatched++;
         $display("FAIL lock_acquired: got locked=%b phase=%0d want locked=1 phase=2",
                  locked, phase);
      end
   endtask

   task automatic test_rotation();
      logic [3:0] seq [6] = '{4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      for (int i = 0; i < 6; i++) begin
         cycle(seq[i], 1'b1, 1'b0);
         compared++;
         if (dut_vec !== model_vec()) begin
            mismatched++;
            $display("FAIL rotation step %0d: got %h want %h", i, dut_vec, model_vec());
         end
      end
      compared++;
      if (rot_count !== 8'd2) begin
         mismatched++;
         $display("FAIL rotation_count: got %0d want 2", rot_count);
      end
   endtask

   task automatic test_seq_err();
      logic [3:0] seq [7] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0001,
                              4'b0010, 4'b0100};
      for (int i = 0; i < 7; i++) begin
         cycle(seq[i], 1'b1, 1'b0);
         compared++;
         if (dut_vec !== model_vec()) begin
            mismatched++;
            $display("FAIL seq_err step %0d: got %h want %h", i, dut_vec, model_vec());
         end
         if (i == 4) begin
            compared++;
            if (seq_err !== 1'b1 || locked !== 1'b0 || err_count !== 8'd1) begin
               mismatched++;
               $display("FAIL seq_err_repeat: got seq_err=%b locked=%b err=%0d want 1 0 1",
                        seq_err, locked, err_count);
            end
         end
      end
      compared++;
      if (locked !== 1'b1) begin
         mismatched++;
         $display("FAIL seq_err_relock: got locked=%b want 1", locked);
      end
   endtask

   task automatic test_illegal();
      logic [3:0] seq [7] = '{4'b0000, 4'b0110, 4'b0001, 4'b0010, 4'b0100,
                              4'b0110, 4'b1000};
      do_reset();
      for (int i = 0; i < 7; i++) begin
         cycle(seq[i], 1'b1, 1'b0);
         compared++;
         if (dut_vec !== model_vec()) begin
            mismatched++;
            $display("FAIL illegal step %0d: got %h want %h", i, dut_vec, model_vec());
         end
         if (i < 2) begin
            compared++;
            if (illegal !== 1'b1 || seq_err !== 1'b0 || phase !== 2'd0) begin
               mismatched++;
               $display("FAIL illegal_search %0d: got ill=%b seq=%b ph=%0d want 1 0 0",
                        i, illegal, seq_err, phase);
            end
         end
         if (i == 5) begin
            compared++;
            if (illegal !== 1'b1 || seq_err !== 1'b1 || locked !== 1'b0) begin
               mismatched++;
               $display("FAIL illegal_locked: got ill=%b seq=%b locked=%b want 1 1 0",
                        illegal, seq_err, locked);
            end
         end
      end
   endtask

   task automatic test_gaps_clr();
      logic [3:0] code [8] = '{4'b0001, 4'b1111, 4'b0010, 4'b0000, 4'b1000,
                               4'b0100, 4'b1000, 4'b0001};
      logic       vld  [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      do_reset();
      for (int i = 0; i < 8; i++) begin
         cycle(code[i], vld[i], (i == 7));
         compared++;
         if (dut_vec !== model_vec()) begin
            mismatched++;
            $display("FAIL gaps step %0d: got %h want %h", i, dut_vec, model_vec());
         end
      end
      compared++;
      if (locked !== 1'b1 || rot_count !== 8'd0 || phase !== 2'd0) begin
         mismatched++;
         $display("FAIL clr_with_rotation: got locked=%b rot=%0d ph=%0d want 1 0 0",
                  locked, rot_count, phase);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      cycle(4'b0001, 1'b1, 1'b0);
      cycle(4'b0010, 1'b1, 1'b0);
      cycle(4'b0100, 1'b1, 1'b0);
      for (int i = 0; i < 18; i++) cycle(4'(1 << ((3 + i) % 4)), 1'b1, 1'b0);
      compared++;
      if (rot_count !== 8'd5 || dut_vec !== model_vec()) begin
         mismatched++;
         $display("FAIL reset_mid_setup: got rot=%0d vec=%h want rot=5 vec=%h",
                  rot_count, dut_vec, model_vec());
      end
      ring_in = 4'b0100; ring_vld = 1'b1;
      #2 reset = 1'b0;
      #1;
      compared++;
      if (dut_vec !== 22'd0) begin
         mismatched++;
         $display("FAIL reset_mid_async: got %h want %h", dut_vec, 22'd0);
      end
      ring_vld = 1'b0;
      model_reset();
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_err_sat();
      int p;
      do_reset();
      cycle(4'b0001, 1'b1, 1'b0);
      cycle(4'b0010, 1'b1, 1'b0);
      cycle(4'b0100, 1'b1, 1'b0);
      p = 2;
      for (int n = 0; n < 260; n++) begin
         cycle(4'(1 << p), 1'b1, 1'b0);
         p = (p + 1) % 4;
         cycle(4'(1 << p), 1'b1, 1'b0);
         p = (p + 1) % 4;
         cycle(4'(1 << p), 1'b1, 1'b0);
         compared++;
         if (dut_vec !== model_vec()) begin
            mismatched++;
            $display("FAIL err_sat round %0d: got %h want %h", n, dut_vec, model_vec());
         end
      end
      cycle(4'(1 << p), 1'b1, 1'b0);
      compared++;
      if (err_count !== 8'd255 || seq_err !== 1'b1) begin
         mismatched++;
         $display("FAIL err_saturate: got err=%0d seq=%b want 255 1", err_count, seq_err);
      end
   endtask

   task automatic test_random();
      logic [3:0] code;
      int         r;
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         r = $urandom_range(0, 99);
         if (m_prev_idx >= 0 && r < 60) code = 4'(1 << ((m_prev_idx + 1) % 4));
         else if (r < 85) code = 4'(1 << $urandom_range(0, 3));
         else code = 4'($urandom);
         cycle(code, ($urandom_range(0, 9) < 8), ($urandom_range(0, 99) < 3));
         compared++;
         if (dut_vec !== model_vec()) begin
            mismatched++;
            $display("FAIL random cycle %0d in=%b: got %h want %h", n, code, dut_vec,
                     model_vec());
         end
      end
   endtask

   initial begin
      compared = 0;
      mismatched = 0;
      reset = 1'b1; ring_in = '0; ring_vld = 1'b0; clr = 1'b0;
      model_reset();
      test_reset();
      test_lock();
      test_rotation();
      test_seq_err();
      test_illegal();
      test_gaps_clr();
      test_reset_mid();
      test_err_sat();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
